// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator feeding the 4:2 compressor tree, four rows per beat.
// Optional feature macro: PP_SIGNED_EN (two's complement operands, W/2 rows); default is unsigned.
module booth_pp_gen #(
  parameter int W = 16
`ifdef PP_SIGNED_EN
  , localparam int ROWS = W / 2
`else
  , localparam int ROWS = W / 2 + 1
`endif
  , localparam int BEATS  = (ROWS + 3) / 4
  , localparam int BEAT_W = $clog2(BEATS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_pp0,
  output logic [2*W-1:0]    out_pp1,
  output logic [2*W-1:0]    out_pp2,
  output logic [2*W-1:0]    out_pp3,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_last
);

`ifdef PP_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q;
  logic [W-1:0]        opA_q, opB_q;
  logic [2*W-1:0]      pp_q [4];
  logic [2*W-1:0]      pp_d [4];
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_q, last_d;
  logic                valid_q;
  logic                accept;
  logic [W-1:0]        srcA, srcB;

  // Row idx = Booth digit idx times A, pre-shifted by 2*idx; rows past ROWS are padding zeros.
  function automatic logic [2*W-1:0] boothRow(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input int idx);
    logic [2*W+2:0] bx;
    logic [2*W-1:0] aExt;
    logic [2*W-1:0] mag;
    logic [2:0]     triple;
    int             sel;
    aExt   = {{W{SIGNED_MODE & a[W-1]}}, a};
    bx     = {{(W+2){SIGNED_MODE & b[W-1]}}, b, 1'b0};
    sel    = (idx < ROWS) ? idx : 0;
    triple = bx[2*sel +: 3];
    case (triple)
      3'b001, 3'b010: mag = aExt;
      3'b011:         mag = aExt << 1;
      3'b100:         mag = -(aExt << 1);
      3'b101, 3'b110: mag = -aExt;
      default:        mag = '0;
    endcase
    if (idx >= ROWS) return '0;
    return mag << (2 * sel);
  endfunction

  assign in_ready  = (state_q == IDLE) | (last_q & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_pp0   = pp_q[0];
  assign out_pp1   = pp_q[1];
  assign out_pp2   = pp_q[2];
  assign out_pp3   = pp_q[3];
  assign out_beat  = beat_q;
  assign out_last  = last_q;

  // A fresh operand pair always starts at beat 0; otherwise the next beat of the latched pair.
  always_comb begin
    srcA   = opA_q;
    srcB   = opB_q;
    beat_d = beat_q + 1'b1;
    if (accept) begin
      srcA   = in_a;
      srcB   = in_b;
      beat_d = '0;
    end
    for (int j = 0; j < 4; j++) begin
      pp_d[j] = boothRow(srcA, srcB, int'(beat_d) * 4 + j);
    end
    last_d = (beat_d == BEAT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      beat_q  <= '0;
      last_q  <= 1'b0;
      opA_q   <= '0;
      opB_q   <= '0;
      for (int j = 0; j < 4; j++) pp_q[j] <= '0;
    end else begin
      if (accept) begin
        opA_q <= in_a;
        opB_q <= in_b;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            beat_q  <= beat_d;
            last_q  <= last_d;
            for (int j = 0; j < 4; j++) pp_q[j] <= pp_d[j];
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!last_q || accept) begin
              beat_q <= beat_d;
              last_q <= last_d;
              for (int j = 0; j < 4; j++) pp_q[j] <= pp_d[j];
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              beat_q  <= '0;
              last_q  <= 1'b0;
              for (int j = 0; j < 4; j++) pp_q[j] <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed bench for booth_pp_gen at W=8 with a streaming random product compare.
// Build with PP_SIGNED_EN defined to exercise the signed configuration.
module tb_booth_pp_gen;

  localparam int W = 8;
`ifdef PP_SIGNED_EN
  localparam int ROWS = W / 2;
`else
  localparam int ROWS = W / 2 + 1;
`endif
  localparam int BEATS  = (ROWS + 3) / 4;
  localparam int BEAT_W = $clog2(BEATS) + 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    out_pp0, out_pp1, out_pp2, out_pp3;
  logic [BEAT_W-1:0] out_beat;
  logic              out_last;

  int checks;
  int failures;

  logic [7:0] dirA [3];
  logic [7:0] dirB [3];

  booth_pp_gen #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pp0   (out_pp0),
    .out_pp1   (out_pp1),
    .out_pp2   (out_pp2),
    .out_pp3   (out_pp3),
    .out_beat  (out_beat),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] prodModel(input logic [7:0] a, input logic [7:0] b);
`ifdef PP_SIGNED_EN
    logic signed [15:0] p;
    p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    return p;
`else
    return {8'h00, a} * {8'h00, b};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Presents one pair at a negedge while idle; returns at the next negedge with beat 0 visible.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    checkOutput("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic receiveTxn(input logic [15:0] expSum, input string tag);
    logic [15:0] sum;
    int          waitCnt;
    sum = '0;
    for (int k = 0; k < BEATS; k++) begin
      waitCnt = 0;
      while (!out_valid && waitCnt < 20) begin
        @(negedge clk);
        waitCnt++;
      end
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_beat"}, 32'(out_beat), 32'(k));
      checkOutput({tag, "_last"}, 32'(out_last), 32'(k == BEATS - 1));
      sum = sum + out_pp0 + out_pp1 + out_pp2 + out_pp3;
      @(negedge clk);
    end
    checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
  endtask

  // Keeps in_valid high across n pairs so transactions run back-to-back.
  task automatic streamPairs(input int n, input bit useRand, input string tag);
    logic [7:0]  curA, curB, nxtA, nxtB;
    logic [15:0] sum;
    if (useRand) begin
      curA = 8'($urandom);
      curB = 8'($urandom);
    end else begin
      curA = dirA[0];
      curB = dirB[0];
    end
    nxtA     = curA;
    nxtB     = curB;
    in_valid = 1'b1;
    in_a     = curA;
    in_b     = curB;
    @(negedge clk);
    for (int p = 0; p < n; p++) begin
      sum = '0;
      for (int k = 0; k < BEATS; k++) begin
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_beat"}, 32'(out_beat), 32'(k));
        sum = sum + out_pp0 + out_pp1 + out_pp2 + out_pp3;
        if (k == 0) begin
          if (p == n - 1) begin
            in_valid = 1'b0;
          end else begin
            if (useRand) begin
              nxtA = 8'($urandom);
              nxtB = 8'($urandom);
            end else begin
              nxtA = dirA[p + 1];
              nxtB = dirB[p + 1];
            end
            in_a = nxtA;
            in_b = nxtB;
          end
        end
        @(negedge clk);
      end
      checkOutput({tag, "_sum"}, 32'(sum), 32'(prodModel(curA, curB)));
      curA = nxtA;
      curB = nxtB;
    end
    checkOutput({tag, "_idle_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    dirA      = '{8'h12, 8'hFF, 8'h7F};
    dirB      = '{8'h34, 8'h02, 8'h80};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_pp0", 32'(out_pp0), 32'd0);
    checkOutput("reset_pp3", 32'(out_pp3), 32'd0);
    checkOutput("reset_beat", 32'(out_beat), 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

`ifndef PP_SIGNED_EN
    // 0xFF*0xFF: digit0 = -1 gives 0xFF01, digit4 = +1 gives 0xFF00, all others zero.
    applyStimulus(8'hFF, 8'hFF);
    checkOutput("t1_b0_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_b0_beat", 32'(out_beat), 32'd0);
    checkOutput("t1_b0_last", 32'(out_last), 32'd0);
    checkOutput("t1_b0_pp0", 32'(out_pp0), 32'h0000FF01);
    checkOutput("t1_b0_pp1", 32'(out_pp1), 32'd0);
    checkOutput("t1_b0_pp2", 32'(out_pp2), 32'd0);
    checkOutput("t1_b0_pp3", 32'(out_pp3), 32'd0);
    @(negedge clk);
    checkOutput("t1_b1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_b1_beat", 32'(out_beat), 32'd1);
    checkOutput("t1_b1_last", 32'(out_last), 32'd1);
    checkOutput("t1_b1_pp0", 32'(out_pp0), 32'h0000FF00);
    checkOutput("t1_b1_pp1", 32'(out_pp1), 32'd0);
    checkOutput("t1_b1_pp2", 32'(out_pp2), 32'd0);
    checkOutput("t1_b1_pp3", 32'(out_pp3), 32'd0);
    checkOutput("t1_b1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("t1_idle_valid", 32'(out_valid), 32'd0);

    applyStimulus(8'h00, 8'hA5);
    checkOutput("t2_b0_rows", 32'(out_pp0 | out_pp1 | out_pp2 | out_pp3), 32'd0);
    checkOutput("t2_b0_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    checkOutput("t2_b1_rows", 32'(out_pp0 | out_pp1 | out_pp2 | out_pp3), 32'd0);
    checkOutput("t2_b1_last", 32'(out_last), 32'd1);
    @(negedge clk);
    applyStimulus(8'h01, 8'h01);
    receiveTxn(16'h0001, "t2_one");

    // 0x5A*0xC3: digits -1,+1,0,-1,+1 give rows FFA6,0168,0000,E980 | 5A00.
    applyStimulus(8'h5A, 8'hC3);
    out_ready = 1'b0;
    checkOutput("t3_hold_pp0", 32'(out_pp0), 32'h0000FFA6);
    checkOutput("t3_hold_pp1", 32'(out_pp1), 32'h00000168);
    checkOutput("t3_hold_pp3", 32'(out_pp3), 32'h0000E980);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_stall_valid", 32'(out_valid), 32'd1);
      checkOutput("t3_stall_beat", 32'(out_beat), 32'd0);
      checkOutput("t3_stall_pp0", 32'(out_pp0), 32'h0000FFA6);
      checkOutput("t3_stall_pp1", 32'(out_pp1), 32'h00000168);
      checkOutput("t3_stall_pp2", 32'(out_pp2), 32'h00000000);
      checkOutput("t3_stall_pp3", 32'(out_pp3), 32'h0000E980);
      checkOutput("t3_stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_b1_beat", 32'(out_beat), 32'd1);
    checkOutput("t3_b1_last", 32'(out_last), 32'd1);
    checkOutput("t3_b1_pp0", 32'(out_pp0), 32'h00005A00);
    @(negedge clk);
    checkOutput("t3_done_valid", 32'(out_valid), 32'd0);

    streamPairs(3, 1'b0, "t4_stream");
`else
    // Signed: -128 * -1; digit0 = -1 negates A to +128, the rest are zero.
    applyStimulus(8'h80, 8'hFF);
    checkOutput("t6_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_last", 32'(out_last), 32'd1);
    checkOutput("t6_pp0", 32'(out_pp0), 32'h00000080);
    checkOutput("t6_pp123", 32'(out_pp1 | out_pp2 | out_pp3), 32'd0);
    @(negedge clk);
    checkOutput("t6_idle_valid", 32'(out_valid), 32'd0);
    applyStimulus(8'hFD, 8'h05);
    receiveTxn(16'hFFF1, "t6_neg3x5");
    streamPairs(3, 1'b0, "t6_stream");
`endif

    applyStimulus(8'hFF, 8'hFF);
    checkOutput("t5_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_rst_pp0", 32'(out_pp0), 32'd0);
    checkOutput("t5_rst_beat", 32'(out_beat), 32'd0);
    checkOutput("t5_rst_last", 32'(out_last), 32'd0);
    checkOutput("t5_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("t5_no_partial", 32'(out_valid), 32'd0);
    applyStimulus(8'h03, 8'h05);
    checkOutput("t5_fresh_pp0", 32'(out_pp0), 32'h00000003);
    checkOutput("t5_fresh_pp1", 32'(out_pp1), 32'h0000000C);
    receiveTxn(16'd15, "t5_fresh");

    streamPairs(10000, 1'b1, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
